// File: rtl/pll_lock_seq_pkg.sv
// Shared types for the DDR3 core PLL lock sequencer.
// State encoding is visible on seq_state for debug.
package pll_lock_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_GATE_DLY  = 3'd3,
        ST_READY     = 3'd4,
        ST_ERROR     = 3'd5
    } seq_state_e;

    function automatic int cnt_width(input int max_cnt);
        int w;
        w = $clog2(max_cnt + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pll_lock_seq_if.sv
// Sequencer <-> PLL / DDR-init signal bundle.
// lock_loss_cnt exists only with PLL_LOCK_SEQ_LOSS_CNT_EN.
interface pll_lock_seq_if #(
    parameter int RW = 2
);
    logic          pll_lock;
    logic          restart_req;
    logic          pll_rst;
    logic          clkout0_gate;
    logic          pll_ready;
    logic          pll_err;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    seq_state;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    logic [15:0]   lock_loss_cnt;

    modport master (
        input  pll_lock, restart_req,
        output pll_rst, clkout0_gate, pll_ready, pll_err,
        output retry_cnt, seq_state, lock_loss_cnt
    );
    modport slave (
        output pll_lock, restart_req,
        input  pll_rst, clkout0_gate, pll_ready, pll_err,
        input  retry_cnt, seq_state, lock_loss_cnt
    );
`else
    modport master (
        input  pll_lock, restart_req,
        output pll_rst, clkout0_gate, pll_ready, pll_err,
        output retry_cnt, seq_state
    );
    modport slave (
        output pll_lock, restart_req,
        input  pll_rst, clkout0_gate, pll_ready, pll_err,
        input  retry_cnt, seq_state
    );
`endif
endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer, synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/pll_lock_seq.sv
// DDR3 core PLL reset/lock/gate sequencer with bounded retries.
// Optional lock-loss counter: define PLL_LOCK_SEQ_LOSS_CNT_EN.
module pll_lock_seq
    import pll_lock_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 64,
    parameter int GATE_DELAY    = 8,
    parameter int MAX_RETRIES   = 3
) (
    input logic             clk,
    input logic             rst,
    pll_lock_seq_if.master  bus
);
    localparam int M1 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int M2 = (SETTLE_CYCLES > GATE_DELAY) ? SETTLE_CYCLES : GATE_DELAY;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW = cnt_width(MAXC);
    localparam int RW = cnt_width(MAX_RETRIES);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LT_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SC_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] GD_LAST  = CW'(GATE_DELAY - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic          rst_q, rst_d;
    logic          gate_q, gate_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          lock_s;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    logic [15:0]   loss_q;
    logic          loss_inc;
`endif

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.pll_lock),
        .q_o (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        retry_inc = (retry_q == RTY_MAX) ? retry_q : retry_q + 1'b1;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        loss_inc  = 1'b0;
`endif
        if (bus.restart_req) begin
            state_d = ST_RST_HOLD;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RST_HOLD: begin
                    if (cnt_q >= RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= LT_LAST) begin
                        cnt_d   = '0;
                        retry_d = retry_inc;
                        state_d = (retry_inc == RTY_MAX) ? ST_ERROR : ST_RST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q >= SC_LAST) begin
                        state_d = ST_GATE_DLY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GATE_DLY: begin
                    if (!lock_s) begin
                        state_d = ST_RST_HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q >= GD_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_READY: begin
                    if (!lock_s) begin
                        state_d  = ST_RST_HOLD;
                        cnt_d    = '0;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
                        loss_inc = 1'b1;
`endif
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_RST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
        // Outputs decoded from the next state so they register with it
        rst_d   = (state_d == ST_RST_HOLD) || (state_d == ST_ERROR);
        gate_d  = (state_d == ST_GATE_DLY) || (state_d == ST_READY);
        ready_d = (state_d == ST_READY);
        err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RST_HOLD;
            cnt_q   <= '0;
            retry_q <= '0;
            rst_q   <= 1'b1;
            gate_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            rst_q   <= rst_d;
            gate_q  <= gate_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != 16'hFFFF)) begin
            loss_q <= loss_q + 16'd1;
        end
    end

    assign bus.lock_loss_cnt = loss_q;
`endif

    assign bus.pll_rst      = rst_q;
    assign bus.clkout0_gate = gate_q;
    assign bus.pll_ready    = ready_q;
    assign bus.pll_err      = err_q;
    assign bus.retry_cnt    = retry_q;
    assign bus.seq_state    = state_q;
endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with a phase/countdown reference model.
module tb_pll_lock_seq;
    localparam int RC = 8;
    localparam int LT = 100;
    localparam int SC = 16;
    localparam int GD = 4;
    localparam int MR = 3;
    localparam int RW = 2;

    localparam int P_HOLD  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_SET   = 2;
    localparam int P_GATE  = 3;
    localparam int P_READY = 4;
    localparam int P_ERR   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pll_lock_seq_if #(.RW(RW)) bus ();

    pll_lock_seq #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SC),
        .GATE_DELAY    (GD),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: phase plus cycles-left countdown
    int m_ph = P_HOLD;
    int m_left = RC;
    int m_retry = 0;
    int m_loss = 0;
    bit m_s1 = 0;
    bit m_s2 = 0;
    bit m_valid = 0;

    always @(posedge clk) begin : model
        int ph, left, rty, loss;
        bit ls;
        ls = m_s2;
        ph = m_ph;
        left = m_left;
        rty = m_retry;
        loss = m_loss;
        if (rst) begin
            ph = P_HOLD; left = RC; rty = 0; loss = 0;
        end else if (bus.restart_req) begin
            ph = P_HOLD; left = RC; rty = 0;
        end else begin
            case (ph)
                P_HOLD: begin
                    left--;
                    if (left == 0) begin ph = P_WAIT; left = LT; end
                end
                P_WAIT: begin
                    if (ls) begin
                        ph = P_SET; left = SC;
                    end else begin
                        left--;
                        if (left == 0) begin
                            rty++;
                            if (rty == MR) ph = P_ERR;
                            else begin ph = P_HOLD; left = RC; end
                        end
                    end
                end
                P_SET: begin
                    if (!ls) begin
                        ph = P_WAIT; left = LT;
                    end else begin
                        left--;
                        if (left == 0) begin ph = P_GATE; left = GD; end
                    end
                end
                P_GATE: begin
                    if (!ls) begin
                        ph = P_HOLD; left = RC;
                    end else begin
                        left--;
                        if (left == 0) begin ph = P_READY; rty = 0; end
                    end
                end
                P_READY: begin
                    if (!ls) begin
                        ph = P_HOLD; left = RC;
                        if (loss < 65535) loss++;
                    end
                end
                default: ;
            endcase
        end
        m_ph <= ph;
        m_left <= left;
        m_retry <= rty;
        m_loss <= loss;
        m_s1 <= rst ? 1'b0 : bus.pll_lock;
        m_s2 <= rst ? 1'b0 : m_s1;
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("c_pll_rst", 32'(bus.pll_rst), 32'(m_ph == P_HOLD || m_ph == P_ERR));
            chk("c_gate", 32'(bus.clkout0_gate), 32'(m_ph == P_GATE || m_ph == P_READY));
            chk("c_ready", 32'(bus.pll_ready), 32'(m_ph == P_READY));
            chk("c_err", 32'(bus.pll_err), 32'(m_ph == P_ERR));
            chk("c_retry", 32'(bus.retry_cnt), 32'(m_retry));
            chk("c_state", 32'(bus.seq_state), 32'(m_ph));
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
            chk("c_loss", 32'(bus.lock_loss_cnt), 32'(m_loss));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max);
        int n = 0;
        while (!bus.pll_ready && n < max) begin
            tick(1);
            n++;
        end
        chk("wait_ready", 32'(bus.pll_ready), 32'd1);
    endtask

    initial begin
        bus.pll_lock = 1'b0;
        bus.restart_req = 1'b0;
        rst = 1'b1;
        tick(2);
        chk("rst_pll_rst", 32'(bus.pll_rst), 32'd1);
        chk("rst_gate", 32'(bus.clkout0_gate), 32'd0);
        chk("rst_ready", 32'(bus.pll_ready), 32'd0);
        chk("rst_err", 32'(bus.pll_err), 32'd0);
        chk("rst_retry", 32'(bus.retry_cnt), 32'd0);
        chk("rst_state", 32'(bus.seq_state), 32'd0);
        rst = 1'b0;

        // nominal lock
        tick(1);
        chk("nom_rst_c1", 32'(bus.pll_rst), 32'd1);
        tick(7);
        chk("nom_rst_c8", 32'(bus.pll_rst), 32'd0);
        chk("nom_wait", 32'(bus.seq_state), 32'd1);
        tick(12);
        bus.pll_lock = 1'b1;
        tick(18);
        chk("nom_gate_pre", 32'(bus.clkout0_gate), 32'd0);
        chk("nom_settle", 32'(bus.seq_state), 32'd2);
        tick(1);
        chk("nom_gate", 32'(bus.clkout0_gate), 32'd1);
        chk("nom_gdly", 32'(bus.seq_state), 32'd3);
        tick(3);
        chk("nom_rdy_pre", 32'(bus.pll_ready), 32'd0);
        tick(1);
        chk("nom_rdy", 32'(bus.pll_ready), 32'd1);
        chk("nom_retry", 32'(bus.retry_cnt), 32'd0);
        chk("nom_prst", 32'(bus.pll_rst), 32'd0);

        // lock loss while READY
        tick(5);
        bus.pll_lock = 1'b0;
        tick(2);
        chk("loss_rdy_hold", 32'(bus.pll_ready), 32'd1);
        tick(1);
        chk("loss_rdy", 32'(bus.pll_ready), 32'd0);
        chk("loss_gate", 32'(bus.clkout0_gate), 32'd0);
        chk("loss_prst", 32'(bus.pll_rst), 32'd1);
        bus.pll_lock = 1'b1;
        tick(7);
        chk("loss_prst7", 32'(bus.pll_rst), 32'd1);
        tick(1);
        chk("loss_prst8", 32'(bus.pll_rst), 32'd0);
        tick(20);
        chk("relock_pre", 32'(bus.pll_ready), 32'd0);
        tick(1);
        chk("relock", 32'(bus.pll_ready), 32'd1);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        chk("loss_cnt", 32'(bus.lock_loss_cnt), 32'd1);
`endif

        // reset mid-READY
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_state", 32'(bus.seq_state), 32'd0);
        chk("mid_rst_prst", 32'(bus.pll_rst), 32'd1);
        chk("mid_rst_gate", 32'(bus.clkout0_gate), 32'd0);
        chk("mid_rst_rdy", 32'(bus.pll_ready), 32'd0);
        rst = 1'b0;
        bus.pll_lock = 1'b0;

        // timeout retries
        tick(107);
        chk("to1_pre", 32'(bus.retry_cnt), 32'd0);
        tick(1);
        chk("to1", 32'(bus.retry_cnt), 32'd1);
        chk("to1_state", 32'(bus.seq_state), 32'd0);
        tick(215);
        chk("to3_pre_err", 32'(bus.pll_err), 32'd0);
        chk("to3_pre_rty", 32'(bus.retry_cnt), 32'd2);
        tick(1);
        chk("to3_err", 32'(bus.pll_err), 32'd1);
        chk("to3_prst", 32'(bus.pll_rst), 32'd1);
        chk("to3_rty", 32'(bus.retry_cnt), 32'd3);
        chk("to3_state", 32'(bus.seq_state), 32'd5);
        tick(40);
        chk("err_stay", 32'(bus.seq_state), 32'd5);

        // restart from ERROR
        bus.restart_req = 1'b1;
        tick(1);
        bus.restart_req = 1'b0;
        chk("rs_state", 32'(bus.seq_state), 32'd0);
        chk("rs_err", 32'(bus.pll_err), 32'd0);
        chk("rs_rty", 32'(bus.retry_cnt), 32'd0);

        // settle glitch
        tick(8);
        chk("gl_wait", 32'(bus.seq_state), 32'd1);
        tick(5);
        bus.pll_lock = 1'b1;
        tick(10);
        bus.pll_lock = 1'b0;
        tick(1);
        bus.pll_lock = 1'b1;
        tick(1);
        chk("gl_settle", 32'(bus.seq_state), 32'd2);
        tick(1);
        chk("gl_back", 32'(bus.seq_state), 32'd1);
        chk("gl_rty", 32'(bus.retry_cnt), 32'd0);
        tick(16);
        chk("gl_gate_pre", 32'(bus.clkout0_gate), 32'd0);
        tick(1);
        chk("gl_gate", 32'(bus.clkout0_gate), 32'd1);
        wait_ready(20);

        // restart from READY, then again mid-SETTLE
        bus.restart_req = 1'b1;
        tick(1);
        bus.restart_req = 1'b0;
        chk("rr_state", 32'(bus.seq_state), 32'd0);
        chk("rr_rdy", 32'(bus.pll_ready), 32'd0);
        tick(8);
        chk("rr_wait", 32'(bus.seq_state), 32'd1);
        tick(1);
        chk("rr_settle", 32'(bus.seq_state), 32'd2);
        tick(5);
        bus.restart_req = 1'b1;
        tick(1);
        bus.restart_req = 1'b0;
        chk("ms_state", 32'(bus.seq_state), 32'd0);
        chk("ms_gate", 32'(bus.clkout0_gate), 32'd0);
        wait_ready(60);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        chk("loss_keep", 32'(bus.lock_loss_cnt), 32'd0);
`endif
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
